// File: rtl/demux1to4_capture_if.sv
// Serial capture bus: data/control toward the capture block, captured word and status back.
interface demux1to4_capture_if;
    logic       d;
    logic [1:0] S;
    logic       En;
    logic       auto;
    logic       start;
    logic [3:0] O;
    logic       o_valid;
    logic       busy;
    logic [1:0] cnt;

    // Source side: drives the serial line and controls, observes the rebuilt word.
    modport master (
        output d, S, En, auto, start,
        input  O, o_valid, busy, cnt
    );

    // Capture side: consumes the serial line, produces the rebuilt word.
    modport slave (
        input  d, S, En, auto, start,
        output O, o_valid, busy, cnt
    );
endinterface

// File: rtl/demux1to4_capture.sv
// 1:4 serial demux/capture: manual per-bit writes or auto 4-bit frame assembly.
module demux1to4_capture #(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux1to4_capture_if.slave   bus
);

    localparam int unsigned WORD_W = 4;
    localparam int unsigned CNT_W  = 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

    logic [1:0]        state_q,  state_nxt;
    logic [WORD_W-1:0] shadow_q, shadow_nxt;
    logic [WORD_W-1:0] o_q,      o_nxt;
    logic [CNT_W-1:0]  cnt_q,    cnt_nxt;
    logic              valid_q,  valid_nxt;
    logic              busy_q,   busy_nxt;

    // State and registered outputs; synchronous active-low reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= {WORD_W{IDLE_VAL}};
            o_q      <= {WORD_W{IDLE_VAL}};
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            shadow_q <= shadow_nxt;
            o_q      <= o_nxt;
            cnt_q    <= cnt_nxt;
            valid_q  <= valid_nxt;
            busy_q   <= busy_nxt;
        end
    end

    // Next state and next register values; last bit loads O directly so it is visible during DONE.
    always_comb begin
        state_nxt  = state_q;
        shadow_nxt = shadow_q;
        o_nxt      = o_q;
        cnt_nxt    = cnt_q;
        valid_nxt  = 1'b0;
        busy_nxt   = busy_q;

        case (state_q)
            IDLE: begin
                busy_nxt = 1'b0;
                cnt_nxt  = '0;
                if (!bus.auto) begin
                    if (!bus.En) begin
                        o_nxt[bus.S] = bus.d;
                        valid_nxt    = 1'b1;
                    end
                end else if (bus.start && !bus.En) begin
                    state_nxt     = SHIFT;
                    shadow_nxt    = {WORD_W{IDLE_VAL}};
                    shadow_nxt[0] = bus.d;
                    cnt_nxt       = CNT_W'(1);
                    busy_nxt      = 1'b1;
                end
            end

            SHIFT: begin
                busy_nxt = 1'b1;
                if (!bus.En) begin
                    shadow_nxt[cnt_q] = bus.d;
                    if (cnt_q == LAST_IDX) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                        o_nxt     = shadow_nxt;
                        valid_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                cnt_nxt   = '0;
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.O       = o_q;
    assign bus.o_valid = valid_q;
    assign bus.busy    = busy_q;
    assign bus.cnt     = cnt_q;

endmodule

// File: tb/tb_demux1to4_capture.sv
// Directed bench for demux1to4_capture: per-cycle vectors {rst_n,d,S,En,auto,start} vs {O,o_valid,busy,cnt}.
module tb_demux1to4_capture;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    demux1to4_capture_if bus ();

    demux1to4_capture #(.IDLE_VAL(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    // Apply one stimulus vector {rst_n, d, S[1:0], En, auto, start}.
    task automatic drive(input logic [6:0] v);
        rst_n     = v[6];
        bus.d     = v[5];
        bus.S     = v[4:3];
        bus.En    = v[2];
        bus.auto  = v[1];
        bus.start = v[0];
    endtask

    // Observed outputs packed as {O[3:0], o_valid, busy, cnt[1:0]}.
    function automatic logic [7:0] obs();
        return {bus.O, bus.o_valid, bus.busy, bus.cnt};
    endfunction

    task automatic test_reset();
        logic [6:0] st [3];
        logic [7:0] ex [3];
        st = '{7'b0_1_00_0_1_1, 7'b0_1_00_0_1_1, 7'b1_0_00_1_1_0};
        ex = '{8'b0000_0_0_00, 8'b0000_0_0_00, 8'b0000_0_0_00};
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            n_chk++;
            if (obs() !== ex[i]) begin
                n_fail++;
                $display("FAIL reset[%0d]: got {O,v,busy,cnt}=%b want %b", i, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_manual();
        logic [6:0] st [5];
        logic [7:0] ex [5];
        st = '{7'b1_1_10_0_0_0, 7'b1_1_00_0_0_0, 7'b1_0_10_0_0_0,
               7'b1_1_11_1_0_0, 7'b1_0_01_1_0_0};
        ex = '{8'b0100_1_0_00, 8'b0101_1_0_00, 8'b0001_1_0_00,
               8'b0001_0_0_00, 8'b0001_0_0_00};
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            n_chk++;
            if (obs() !== ex[i]) begin
                n_fail++;
                $display("FAIL manual[%0d]: got {O,v,busy,cnt}=%b want %b", i, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_auto_frame();
        logic [6:0] st [5];
        logic [7:0] ex [5];
        st = '{7'b1_1_00_0_1_1, 7'b1_0_00_0_1_0, 7'b1_1_00_0_1_0,
               7'b1_1_00_0_1_0, 7'b1_0_00_1_1_0};
        ex = '{8'b0001_0_1_01, 8'b0001_0_1_10, 8'b0001_0_1_11,
               8'b1101_1_1_00, 8'b1101_0_0_00};
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            n_chk++;
            if (obs() !== ex[i]) begin
                n_fail++;
                $display("FAIL auto_frame[%0d]: got {O,v,busy,cnt}=%b want %b", i, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [6:0] st [8];
        logic [7:0] ex [8];
        st = '{7'b1_1_00_0_1_1, 7'b1_1_00_0_1_0, 7'b1_0_00_1_1_0, 7'b1_1_00_1_1_0,
               7'b1_0_00_1_1_0, 7'b1_0_00_0_1_0, 7'b1_0_00_0_1_0, 7'b1_1_00_1_1_0};
        ex = '{8'b1101_0_1_01, 8'b1101_0_1_10, 8'b1101_0_1_10, 8'b1101_0_1_10,
               8'b1101_0_1_10, 8'b1101_0_1_11, 8'b0011_1_1_00, 8'b0011_0_0_00};
        for (int i = 0; i < 8; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            n_chk++;
            if (obs() !== ex[i]) begin
                n_fail++;
                $display("FAIL stall[%0d]: got {O,v,busy,cnt}=%b want %b", i, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] st [10];
        logic [7:0] ex [10];
        st = '{7'b1_1_00_0_1_1, 7'b1_1_00_0_1_0, 7'b0_1_00_0_1_0, 7'b1_0_00_1_1_0,
               7'b1_0_00_1_1_0, 7'b1_0_00_0_1_1, 7'b1_1_00_0_1_0, 7'b1_1_00_0_1_0,
               7'b1_0_00_0_1_0, 7'b1_0_00_1_1_0};
        ex = '{8'b0011_0_1_01, 8'b0011_0_1_10, 8'b0000_0_0_00, 8'b0000_0_0_00,
               8'b0000_0_0_00, 8'b0000_0_1_01, 8'b0000_0_1_10, 8'b0000_0_1_11,
               8'b0110_1_1_00, 8'b0110_0_0_00};
        for (int i = 0; i < 10; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            n_chk++;
            if (obs() !== ex[i]) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got {O,v,busy,cnt}=%b want %b", i, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_mode_change();
        logic [6:0] st [7];
        logic [7:0] ex [7];
        // Mid-frame: auto dropped, S=3, start toggled; DONE-cycle inputs must also be ignored.
        st = '{7'b1_1_00_0_1_1, 7'b1_1_11_0_0_0, 7'b1_0_11_0_0_1, 7'b1_0_11_0_0_0,
               7'b1_1_11_0_0_0, 7'b1_1_11_1_0_0, 7'b1_1_11_0_0_0};
        ex = '{8'b0110_0_1_01, 8'b0110_0_1_10, 8'b0110_0_1_11, 8'b0011_1_1_00,
               8'b0011_0_0_00, 8'b0011_0_0_00, 8'b1011_1_0_00};
        for (int i = 0; i < 7; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            n_chk++;
            if (obs() !== ex[i]) begin
                n_fail++;
                $display("FAIL mode_change[%0d]: got {O,v,busy,cnt}=%b want %b", i, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] st [6];
        logic [7:0] ex [6];
        // Frame 0,0,0,1 followed immediately by a start in the first IDLE cycle.
        st = '{7'b1_0_00_0_1_1, 7'b1_0_00_0_1_0, 7'b1_0_00_0_1_0, 7'b1_1_00_0_1_0,
               7'b1_1_00_0_1_1, 7'b1_1_00_0_1_1};
        ex = '{8'b1011_0_1_01, 8'b1011_0_1_10, 8'b1011_0_1_11, 8'b1000_1_1_00,
               8'b1000_0_0_00, 8'b1000_0_1_01};
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            n_chk++;
            if (obs() !== ex[i]) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got {O,v,busy,cnt}=%b want %b", i, obs(), ex[i]);
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        drive(7'b0_0_00_1_0_0);
        test_reset();
        test_manual();
        test_auto_frame();
        test_stall();
        test_reset_mid_frame();
        test_mode_change();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
